// File: rtl/edge_scan_ctrl_if.sv
// Frame-buffer read port and edge-detector streaming port of edge_scan_ctrl.
// master = scan controller, slave = memory/detector side.
interface edge_scan_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0]        mem_data;
  logic              det_clr_n;
  logic              det_en;
  logic [9:0]        det_row;
  logic [9:0]        det_col;
  logic              det_hscan;
  logic              det_vscan;
  logic [9:0]        det_data;
  logic [19:0]       det_row_bounds;
  logic [19:0]       det_col_bounds;
  logic [1:0]        det_finish;

  modport master (
    output mem_rd, mem_addr, det_clr_n, det_en, det_row, det_col,
           det_hscan, det_vscan, det_data,
    input  mem_data, det_row_bounds, det_col_bounds, det_finish
  );

  modport slave (
    input  mem_rd, mem_addr, det_clr_n, det_en, det_row, det_col,
           det_hscan, det_vscan, det_data,
    output mem_data, det_row_bounds, det_col_bounds, det_finish
  );
endinterface

// File: rtl/edge_scan_ctrl.sv
// Bounding-box search sequencer: clears the edge detector, streams the frame
// row-major then column-major, waits for finish and latches the box edges.
module edge_scan_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int RD_LAT      = 1,
  parameter int FIN_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] box_top,
  output logic [9:0] box_bottom,
  output logic [9:0] box_left,
  output logic [9:0] box_right,
  output logic       box_valid,
  edge_scan_ctrl_if.master bus
);

  localparam int CNT_MAX = (FIN_TIMEOUT > RD_LAT) ? FIN_TIMEOUT : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_HSCAN, S_HDRAIN, S_VSCAN, S_VDRAIN, S_WAIT_FIN, S_DONE
  } state_t;

  state_t                   state_q;
  logic                     busy_q, done_q, err_q, box_valid_q, clr_n_q, mem_rd_q;
  logic [9:0]               top_q, bottom_q, left_q, right_q;
  logic [9:0]               row_q, col_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [RD_LAT-1:0]        pipe_en_q, pipe_h_q, pipe_v_q;
  logic [RD_LAT-1:0][9:0]   pipe_row_q, pipe_col_q;

  logic col_end, row_end, last_px, drain_end, wait_end, kill;

  assign col_end   = (col_q == 10'(H_RES - 1));
  assign row_end   = (row_q == 10'(V_RES - 1));
  assign last_px   = col_end && row_end;
  assign drain_end = (cnt_q == CNT_W'(RD_LAT - 1));
  assign wait_end  = (cnt_q == CNT_W'(FIN_TIMEOUT - 1));
  assign kill      = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      box_valid_q <= 1'b0;
      clr_n_q     <= 1'b1;
      mem_rd_q    <= 1'b0;
      top_q       <= '0;
      bottom_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      pipe_en_q   <= '0;
      pipe_h_q    <= '0;
      pipe_v_q    <= '0;
      pipe_row_q  <= '0;
      pipe_col_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // Tags ride alongside the outstanding read so they emerge with its data.
      for (int unsigned i = RD_LAT - 1; i > 0; i--) begin
        pipe_en_q[i]  <= pipe_en_q[i-1];
        pipe_h_q[i]   <= pipe_h_q[i-1];
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_row_q[i] <= pipe_row_q[i-1];
        pipe_col_q[i] <= pipe_col_q[i-1];
      end
      pipe_en_q[0]  <= mem_rd_q;
      pipe_h_q[0]   <= mem_rd_q && (state_q == S_HSCAN);
      pipe_v_q[0]   <= mem_rd_q && (state_q == S_VSCAN);
      pipe_row_q[0] <= row_q;
      pipe_col_q[0] <= col_q;

      if (kill) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        mem_rd_q    <= 1'b0;
        box_valid_q <= 1'b0;
        clr_n_q     <= 1'b1;
        pipe_en_q   <= '0;
        pipe_h_q    <= '0;
        pipe_v_q    <= '0;
        pipe_row_q  <= '0;
        pipe_col_q  <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q     <= S_CLR;
              busy_q      <= 1'b1;
              box_valid_q <= 1'b0;
              err_q       <= 1'b0;
              clr_n_q     <= 1'b0;
            end
          end
          S_CLR: begin
            clr_n_q  <= 1'b1;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            mem_rd_q <= 1'b1;
            state_q  <= S_HSCAN;
          end
          S_HSCAN: begin
            if (last_px) begin
              mem_rd_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_HDRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (col_end) begin
                col_q <= '0;
                row_q <= row_q + 10'd1;
              end else begin
                col_q <= col_q + 10'd1;
              end
            end
          end
          S_HDRAIN: begin
            if (drain_end) begin
              row_q    <= '0;
              col_q    <= '0;
              addr_q   <= '0;
              mem_rd_q <= 1'b1;
              state_q  <= S_VSCAN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_VSCAN: begin
            if (last_px) begin
              mem_rd_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_VDRAIN;
            end else if (row_end) begin
              row_q  <= '0;
              col_q  <= col_q + 10'd1;
              addr_q <= ADDR_W'(col_q) + ADDR_W'(1);
            end else begin
              row_q  <= row_q + 10'd1;
              addr_q <= addr_q + ADDR_W'(H_RES);
            end
          end
          S_VDRAIN: begin
            if (drain_end) begin
              cnt_q   <= '0;
              state_q <= S_WAIT_FIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_WAIT_FIN: begin
            if (bus.det_finish == 2'b11) begin
              top_q    <= bus.det_row_bounds[9:0];
              bottom_q <= bus.det_row_bounds[19:10];
              left_q   <= bus.det_col_bounds[9:0];
              right_q  <= bus.det_col_bounds[19:10];
              state_q  <= S_DONE;
            end else if (wait_end) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DONE: begin
            done_q      <= 1'b1;
            box_valid_q <= ~err_q;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign box_valid  = box_valid_q;
  assign box_top    = top_q;
  assign box_bottom = bottom_q;
  assign box_left   = left_q;
  assign box_right  = right_q;

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = addr_q;
  assign bus.det_clr_n = clr_n_q;
  assign bus.det_en    = pipe_en_q[RD_LAT-1];
  assign bus.det_hscan = pipe_h_q[RD_LAT-1];
  assign bus.det_vscan = pipe_v_q[RD_LAT-1];
  assign bus.det_row   = pipe_row_q[RD_LAT-1];
  assign bus.det_col   = pipe_col_q[RD_LAT-1];
  assign bus.det_data  = pipe_en_q[RD_LAT-1] ? bus.mem_data : '0;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Bench for edge_scan_ctrl on an 8x6 frame, RD_LAT=1 (A) and RD_LAT=3 (B) side by side,
// with stub frame buffers returning addr[9:0] and stub detectors raising finish per pass.
module tb_edge_scan_ctrl;
  localparam int H = 8;
  localparam int V = 6;
  localparam int NPIX = H * V;

  typedef struct packed {
    logic [18:0] addr;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        h;
    logic        v;
  } pix_t;

  typedef struct {
    bit          stuck;
    logic [19:0] rb, cb;
    int          lat_a, lat_b;
    logic [9:0]  top, bot, left, right;
    bit          valid, err;
  } vec_t;

  logic clk, rst, start, abort, stuck, mon_on;
  logic [19:0] rb, cb;
  logic busyA, doneA, errA, validA, busyB, doneB, errB, validB;
  logic [9:0] topA, botA, leftA, rightA, topB, botB, leftB, rightB;

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int rd_idx[2], en_cnt[2], done_cnt[2], done_cyc[2];
  pix_t qA[$], qB[$];
  vec_t vecs[3];

  edge_scan_ctrl_if #(.ADDR_W(19)) busA ();
  edge_scan_ctrl_if #(.ADDR_W(19)) busB ();

  edge_scan_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(19), .RD_LAT(1), .FIN_TIMEOUT(16)) dutA (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busyA), .done(doneA), .err(errA),
    .box_top(topA), .box_bottom(botA), .box_left(leftA), .box_right(rightA),
    .box_valid(validA), .bus(busA));

  edge_scan_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(19), .RD_LAT(3), .FIN_TIMEOUT(16)) dutB (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busyB), .done(doneB), .err(errB),
    .box_top(topB), .box_bottom(botB), .box_left(leftB), .box_right(rightB),
    .box_valid(validB), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub frame buffers: data = addr[9:0], RD_LAT cycles later.
  logic [9:0] memA_q;
  logic [2:0][9:0] memB_q;
  always @(posedge clk or negedge rst)
    if (!rst) memA_q <= '0; else memA_q <= busA.mem_addr[9:0];
  always @(posedge clk or negedge rst)
    if (!rst) memB_q <= '0; else memB_q <= {memB_q[1:0], busB.mem_addr[9:0]};
  assign busA.mem_data = memA_q;
  assign busB.mem_data = memB_q[2];

  // Stub detectors: finish bit set once the last pixel of each pass is seen.
  logic [1:0] finA_q, finB_q;
  always @(posedge clk or negedge rst)
    if (!rst || !busA.det_clr_n) finA_q <= 2'b00;
    else if (busA.det_en && busA.det_row == 10'(V-1) && busA.det_col == 10'(H-1))
      finA_q <= finA_q | {busA.det_vscan, busA.det_hscan};
  always @(posedge clk or negedge rst)
    if (!rst || !busB.det_clr_n) finB_q <= 2'b00;
    else if (busB.det_en && busB.det_row == 10'(V-1) && busB.det_col == 10'(H-1))
      finB_q <= finB_q | {busB.det_vscan, busB.det_hscan};
  assign busA.det_finish = {finA_q[1] & ~stuck, finA_q[0]};
  assign busB.det_finish = {finB_q[1] & ~stuck, finB_q[0]};
  assign busA.det_row_bounds = rb;
  assign busA.det_col_bounds = cb;
  assign busB.det_row_bounds = rb;
  assign busB.det_col_bounds = cb;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic pix_t exp_pix(input int idx);
    pix_t p;
    int k;
    if (idx < NPIX) begin
      p.row = 10'(idx / H); p.col = 10'(idx % H); p.h = 1'b1; p.v = 1'b0;
    end else begin
      k = idx - NPIX;
      p.col = 10'(k / V); p.row = 10'(k % V); p.h = 1'b0; p.v = 1'b1;
    end
    p.addr = 19'(int'(p.row) * H + int'(p.col));
    return p;
  endfunction

  task automatic mon(input int k, input logic rd, input logic [18:0] addr,
                     input logic en, input logic [31:0] got);
    pix_t e;
    if (rd) begin
      e = exp_pix(rd_idx[k]);
      chk($sformatf("mem_addr[%0d] read %0d", k, rd_idx[k]), addr, e.addr);
      rd_idx[k]++;
      if (k == 0) qA.push_back(e); else qB.push_back(e);
    end
    if (en) begin
      en_cnt[k]++;
      if ((k == 0 ? qA.size() : qB.size()) == 0) chk($sformatf("det_en[%0d] unexpected", k), 1, 0);
      else begin
        e = (k == 0) ? qA.pop_front() : qB.pop_front();
        chk($sformatf("det data/row/col/tags[%0d] #%0d", k, en_cnt[k]), got,
            {e.addr[9:0], e.row, e.col, e.h, e.v});
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      mon(0, busA.mem_rd, busA.mem_addr, busA.det_en,
          {busA.det_data, busA.det_row, busA.det_col, busA.det_hscan, busA.det_vscan});
      mon(1, busB.mem_rd, busB.mem_addr, busB.det_en,
          {busB.det_data, busB.det_row, busB.det_col, busB.det_hscan, busB.det_vscan});
    end
    if (doneA) begin done_cnt[0]++; if (done_cyc[0] < 0) done_cyc[0] = cyc; end
    if (doneB) begin done_cnt[1]++; if (done_cyc[1] < 0) done_cyc[1] = cyc; end
  end

  task automatic check_reset(input string nm);
    chk({nm, " ctlA"}, {busyA, doneA, errA, validA, busA.mem_rd, busA.det_en,
                        busA.det_hscan, busA.det_vscan}, 0);
    chk({nm, " boxA"}, {topA, botA, leftA, rightA}, 0);
    chk({nm, " detA"}, {busA.mem_addr, busA.det_row, busA.det_col, busA.det_data}, 0);
    chk({nm, " ctlB"}, {busyB, doneB, errB, validB, busB.mem_rd, busB.det_en}, 0);
    chk({nm, " det_clr_n"}, {busA.det_clr_n, busB.det_clr_n}, 2'b11);
  endtask

  task automatic begin_frame(input vec_t v, output int s);
    rb = v.rb; cb = v.cb; stuck = v.stuck;
    qA.delete(); qB.delete();
    for (int k = 0; k < 2; k++) begin
      rd_idx[k] = 0; en_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1;
    end
    mon_on = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    chk("CLR det_clr_n low", {busA.det_clr_n, busB.det_clr_n}, 2'b00);
    chk("CLR busy/err/valid/rd", {busyA, errA, validA, busA.mem_rd, busyB}, 5'b10001);
    @(negedge clk);
    chk("HSCAN first read", {busA.det_clr_n, busA.mem_rd, busA.mem_addr}, {1'b1, 1'b1, 19'd0});
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int s;
    begin_frame(v, s);
    for (int i = 0; i < 400 && (done_cyc[0] < 0 || done_cyc[1] < 0); i++) @(negedge clk);
    chk({nm, " latency A"}, done_cyc[0] - s, v.lat_a);
    chk({nm, " latency B"}, done_cyc[1] - s, v.lat_b);
    @(negedge clk);
    chk({nm, " box A"}, {topA, botA, leftA, rightA}, {v.top, v.bot, v.left, v.right});
    chk({nm, " box B"}, {topB, botB, leftB, rightB}, {v.top, v.bot, v.left, v.right});
    chk({nm, " flags A"}, {busyA, doneA, errA, validA}, {2'b00, v.err, v.valid});
    chk({nm, " flags B"}, {busyB, doneB, errB, validB}, {2'b00, v.err, v.valid});
    chk({nm, " counts A"}, {16'(rd_idx[0]), 16'(en_cnt[0]), 16'(qA.size()), 16'(done_cnt[0])},
        {16'(2*NPIX), 16'(2*NPIX), 16'd0, 16'd1});
    chk({nm, " counts B"}, {16'(rd_idx[1]), 16'(en_cnt[1]), 16'(qB.size()), 16'(done_cnt[1])},
        {16'(2*NPIX), 16'(2*NPIX), 16'd0, 16'd1});
    mon_on = 1'b0;
  endtask

  initial begin
    int s, dA, dB;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stuck = 1'b0; mon_on = 1'b0;
    rb = '0; cb = '0;
    for (int k = 0; k < 2; k++) begin
      rd_idx[k] = 0; en_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1;
    end
    //        stuck  row bounds {bot,top}   col bounds {right,left} latA latB top bot left right valid err
    vecs[0] = '{1'b0, {10'd5, 10'd1}, {10'd6, 10'd2}, 101, 105, 10'd1, 10'd5, 10'd2, 10'd6, 1'b1, 1'b0};
    vecs[1] = '{1'b1, {10'd4, 10'd3}, {10'd7, 10'd0}, 116, 120, 10'd1, 10'd5, 10'd2, 10'd6, 1'b0, 1'b1};
    vecs[2] = '{1'b0, {10'd3, 10'd0}, {10'd5, 10'd4}, 101, 105, 10'd0, 10'd3, 10'd4, 10'd5, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Abort in the middle of the column pass.
    begin_frame(vecs[0], s);
    while (cyc < s + 60) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mon_on = 1'b0;
    qA.delete(); qB.delete();
    chk("abort busy/rd/en/valid A", {busyA, busA.mem_rd, busA.det_en, validA, doneA}, 0);
    chk("abort busy/rd/en B", {busyB, busB.mem_rd, busB.det_en, doneB}, 0);
    dA = done_cnt[0]; dB = done_cnt[1];
    repeat (120) @(negedge clk);
    chk("abort no done", {16'(done_cnt[0] - dA), 16'(done_cnt[1] - dB), busyA, busyB}, 0);
    run_frame(vecs[0], "after abort");

    // Stray start while busy, then reset mid row pass.
    begin_frame(vecs[0], s);
    while (cyc < s + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start while busy ignored", {busyA, busA.det_clr_n, busA.mem_rd}, 3'b111);
    while (cyc < s + 20) @(negedge clk);
    chk("HSCAN addr at +20", busA.mem_addr, 19'd19);
    mon_on = 1'b0;
    rst = 1'b0;
    #1;
    check_reset("mid-run reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(vecs[0], "after reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/edge_scan_ctrl.md
Name: edge_scan_ctrl

Overview:
- Sequences one bounding-box search over a binarised frame stored in the frame buffer.
- Clears the edge detector, then streams the frame to it twice: a row-major pass with hscan, then a column-major pass with vscan. Each pixel is tagged with its row/col.
- Waits for the detector's finish flags, latches the four box edges and hands them to the digit-crop stage with a done pulse.

Parameters:
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- RD_LAT, 1, frame-buffer read latency in cycles (1..3).
- FIN_TIMEOUT, 16, cycles allowed in WAIT_FIN before error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process the current frame
- abort  in  1  synchronous cancel
- busy  out  1  high from accepted start until DONE or abort
- done  out  1  one-cycle pulse, box outputs valid
- err  out  1  finish timeout on last run; held until next accepted start
- mem_rd  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_W  read address, row*H_RES+col
- mem_data  in  10  pixel returned RD_LAT cycles after mem_rd
- det_clr_n  out  1  detector clear, active-low; integrator ANDs with rst
- det_en  out  1  detector enable
- det_row  out  10  row of det_data
- det_col  out  10  column of det_data
- det_hscan  out  1  row-pass tag
- det_vscan  out  1  column-pass tag
- det_data  out  10  pixel to detector, equal to mem_data
- det_row_bounds  in  20  [9:0] top, [19:10] bottom
- det_col_bounds  in  20  [9:0] left, [19:10] right
- det_finish  in  2  [0] rows done, [1] cols done
- box_top, box_bottom, box_left, box_right  out  10 each  latched edges
- box_valid  out  1  high from done until next accepted start, abort or reset

Behaviour:
- Reset values:
  - det_clr_n=1.
  - All other outputs 0.
  - State IDLE.
  - Address, row, col counters and pipeline tags 0.
- States: IDLE, CLR, HSCAN, HDRAIN, VSCAN, VDRAIN, WAIT_FIN, DONE.
- IDLE: start=1 -> CLR. In the same edge, busy<=1, box_valid<=0, err<=0. start in any other state is ignored.
- CLR: one cycle with det_clr_n=0. Then det_clr_n=1, row=col=0, mem_addr=0, go to HSCAN.
- HSCAN: mem_rd=1 every cycle.
  - col increments each cycle and mem_addr increments by 1.
  - At col=H_RES-1: col<=0, row<=row+1.
  - Issuing (V_RES-1,H_RES-1) -> HDRAIN. Exactly H_RES*V_RES reads are issued.
- VSCAN: column-major order.
  - row increments each cycle and mem_addr += H_RES.
  - At row=V_RES-1: row<=0, col<=col+1, mem_addr<=col+1.
  - Issuing (V_RES-1,H_RES-1) -> VDRAIN.
  - Addition is unsigned ADDR_W-bit; it never exceeds H_RES*V_RES-1.
- Alignment pipeline: the row/col/hscan/vscan tags travel through an RD_LAT-deep shift register alongside mem_rd.
  - det_en, det_hscan, det_vscan, det_row, det_col and det_data=mem_data are presented in the cycle the read data returns.
  - det_hscan and det_vscan are never both 1.
  - det_en=0 on every cycle with no returning data.
- HDRAIN: RD_LAT cycles with mem_rd=0 while the pipeline empties, then VSCAN with row=col=0, mem_addr=0.
- VDRAIN: RD_LAT cycles, then WAIT_FIN.
- WAIT_FIN: with det_finish==2'b11, latch:
  - box_top=det_row_bounds[9:0], box_bottom=[19:10]
  - box_left=det_col_bounds[9:0], box_right=[19:10]
  - then go to DONE.
- WAIT_FIN timeout: after FIN_TIMEOUT cycles without 2'b11, err<=1. Box registers are not updated and the block goes to DONE.
- DONE: one cycle. done=1, box_valid<=~err, busy<=0, -> IDLE.
- Latency: start edge to done = 1 + 2*H_RES*V_RES + 2*RD_LAT + W + 1 cycles, W = WAIT_FIN cycles (>=1).
- abort=1 in any non-IDLE state:
  - Next state IDLE; busy, mem_rd, det_en, box_valid cleared.
  - Pipeline tags flushed; data still returning is discarded, not forwarded.
  - done is not pulsed.
  - abort has priority over start, timeout and finish.
- rst mid-operation: immediate return to reset values. The next start performs a full CLR.

Test Plan:
- Reduced sim H_RES=8, V_RES=6, RD_LAT=1, stub memory returning addr[9:0]:
  - Start -> mem_addr 0,1,...,47 during HSCAN, then 0,8,16,...,40,1,9,... during VSCAN.
  - det_row/det_col match the returned data index in every cycle.
  - det_en high for exactly 96 cycles.
- Stub detector asserts det_finish=11 on the first WAIT_FIN cycle with bounds {bottom=5,top=1}, {right=6,left=2} -> done at cycle 1+96+2+1+1=101 after the start edge, box=(1,5,2,6), box_valid=1, err=0.
- RD_LAT=3 -> mem_data aligned to tags with 3-cycle offset, no det_en during the drain windows, start-to-done latency 105 cycles.
- det_finish stuck at 01 -> after 16 WAIT_FIN cycles err=1, done pulses, box_valid=0, box registers unchanged from the previous run.
- abort mid-VSCAN -> next cycle busy=0, mem_rd=0; det_en=0 in the flushed cycle; no done. A fresh start shows det_clr_n low for one cycle and addresses restart at 0.
- start while busy and rst low mid-HSCAN -> start ignored. Under reset all outputs return to reset values, det_clr_n=1.
